ram_responder: RTL and testbench
================================

Name: ram_responder

Overview:
- Backing-memory responder for the direct-mapped cache: the slave end of the cache↔RAM request/response interface.
- Accepts one read or write request at a time from the cache controller and models fixed main-memory latency.
- After that latency it returns a one-cycle response pulse (the cache's response_ram) with read data.
- Word-addressed storage; the address is reduced modulo DEPTH, matching the cache's index convention.

Parameters:
- DATA_W, 32, data word width
- ADDR_W, 32, request address width
- DEPTH, 4096, number of words; must be a power of 2; index = address % DEPTH = address[log2(DEPTH)-1:0]
- LATENCY, 4, cycles from request acceptance to response; legal range 1..15

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  cache presents a request
- req_ready  out  1  responder can accept a request (high only in IDLE)
- req_write  in  1  1 = write (mode=1), 0 = read
- req_address  in  ADDR_W  word address
- req_data  in  DATA_W  write data
- resp_valid  out  1  one-cycle response pulse
- resp_write  out  1  echo of the accepted request's req_write, valid with resp_valid
- resp_data  out  DATA_W  read data (old word for writes); held until next response
- busy  out  1  request in flight (WAIT state)

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, req_ready=1, resp_valid=0, resp_write=0, resp_data=0, busy=0, counter=0. Memory contents are not cleared by reset; the array is zero-initialised at time 0.
- FSM states: IDLE, WAIT.
- IDLE: at an edge with req_valid=1, latch write, index, data; counter=LATENCY-1; go to WAIT; busy=1, req_ready=0.
- Special case LATENCY=1: respond directly from IDLE at the edge after acceptance; no WAIT cycles counted.
- WAIT, counter≠0: decrement counter.
- WAIT, counter=0 at an edge:
  - resp_valid=1 for that one cycle.
  - resp_data = mem[index] sampled before any write.
  - If a write, mem[index] = latched data at this edge.
  - Return to IDLE.
- Timing: request accepted at edge k → resp_valid high during the cycle after edge k+LATENCY. req_ready is high again in that same cycle.
- Throughput: a request held valid is re-accepted at edge k+LATENCY+1, giving one request per LATENCY+1 cycles.
- Inputs are ignored while not in IDLE; changes on req_* during WAIT have no effect.
- resp_valid deasserts at the next edge unconditionally; the cache has no back-pressure.
- Reset during WAIT: the request is aborted, no memory write occurs, and no response is issued.
- Address aliasing: upper address bits are dropped silently; no error is flagged.
- Widths: the counter is 4 bits; index is log2(DEPTH) bits.

Decomposition:
- Shared package cache_pkg holds:
  - DATA_W, ADDR_W, DEPTH constants, shared with the cache
  - index_t typedef (log2(DEPTH) bits)
  - enum resp_state_t {IDLE, WAIT}
  - index_of() function (address modulo DEPTH)
- One natural sub-module, ram_array: single-port synchronous read-before-write memory, DEPTH x DATA_W.

Test Plan:
- Reset, then write 14528 to address 0 → resp_valid pulses exactly LATENCY=4 cycles after acceptance, resp_write=1, resp_data=0; mem[0]=14528.
- Write 526421 to address 2816867292, then read address 3036 → read resp_data=526421 (alias via % 4096).
- Write 25369366 to 1001425, then write 14528 to 1001425, then read 1001425 → second write's resp_data=25369366; read returns 14528.
- Hold req_valid=1 for three back-to-back reads of address 0 → acceptances 5 cycles apart; req_ready=0 and busy=1 during each WAIT; three resp_valid pulses each equal to 14528.
- Issue a write of 99 to 2001, assert rst_n=0 two cycles later, then read 2001 → no response for the aborted write; read returns the previous value, not 99.
- Change req_address and req_data during WAIT → response reflects the originally latched request only.

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache/RAM constants, index type, responder states
// Contents: DATA_W, ADDR_W, DEPTH, INDEX_W, index_t, resp_state_t, index_of()
package cache_pkg;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int DEPTH   = 4096;
  localparam int INDEX_W = $clog2(DEPTH);

  typedef logic [INDEX_W-1:0] index_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } resp_state_t;

  // DEPTH is a power of two, so address % DEPTH is a truncation to the low bits.
  function automatic index_t index_of(input logic [ADDR_W-1:0] address);
    return index_t'(address);
  endfunction

endpackage

// File: rtl/ram_responder_if.sv
// rtl/ram_responder_if.sv - cache<->RAM request/response interface
// Signals: req_valid, req_ready, req_write, req_address, req_data (request),
//          resp_valid, resp_write, resp_data (response), busy (request in flight)
// Modports: master = cache controller, slave = RAM responder
interface ram_responder_if;
  import cache_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_address;
  logic [DATA_W-1:0] req_data;
  logic              resp_valid;
  logic              resp_write;
  logic [DATA_W-1:0] resp_data;
  logic              busy;

  modport master (
    output req_valid, req_write, req_address, req_data,
    input  req_ready, resp_valid, resp_write, resp_data, busy
  );

  modport slave (
    input  req_valid, req_write, req_address, req_data,
    output req_ready, resp_valid, resp_write, resp_data, busy
  );

endinterface

// File: rtl/ram_responder_ram_array.sv
// rtl/ram_responder_ram_array.sv - single-port read-before-write memory, DEPTH x DATA_W
// Ports: clk, rst_n (clears read register only), en (access strobe), we (write),
//        addr (index), wdata (write data), rdata (old word at addr, held between accesses)
module ram_array
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  index_t            addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  // Contents start at zero and survive reset.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  // A reset edge suppresses the write so an aborted request leaves memory untouched.
  always_ff @(posedge clk) begin
    if (rst_n && en && we) begin
      mem[addr] <= wdata;
    end
  end

  // Read register samples the word before this edge's write lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - backing-memory responder with fixed latency for the cache
// Ports: clk, rst_n (sync, active-low), bus (ram_responder_if.slave)
// Parameter: LATENCY (1..15) edges from request acceptance to response edge
module ram_responder
  import cache_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  ram_responder_if.slave  bus
);

  localparam logic [3:0] CNT_START = 4'(LATENCY - 1);

  resp_state_t       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              accept;
  logic              do_resp;
  logic              wr_q;
  index_t            idx_q;
  logic [DATA_W-1:0] data_q;
  logic              resp_valid_q;
  logic              resp_write_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // With LATENCY=1 the counter starts at zero, so the first WAIT edge responds.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    do_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          cnt_d   = CNT_START;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          do_resp = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch; inputs seen outside IDLE never reach these registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q   <= 1'b0;
      idx_q  <= '0;
      data_q <= '0;
    end else if (accept) begin
      wr_q   <= bus.req_write;
      idx_q  <= index_of(bus.req_address);
      data_q <= bus.req_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_write_q <= 1'b0;
    end else begin
      resp_valid_q <= do_resp;
      if (do_resp) begin
        resp_write_q <= wr_q;
      end
    end
  end

  ram_array u_ram_array (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (do_resp),
    .we    (wr_q),
    .addr  (idx_q),
    .wdata (data_q),
    .rdata (bus.resp_data)
  );

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.busy       = (state_q == WAIT);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_write = resp_write_q;

endmodule

// File: tb/tb_ram_responder.sv
// tb/tb_ram_responder.sv - self-checking bench for ram_responder
module tb_ram_responder;

  localparam int L   = 4;
  localparam int DEP = 4096;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  ram_responder_if bus ();

  ram_responder #(.LATENCY(L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: one outstanding request, response L edges after acceptance.
  int          cyc;
  bit          pend;
  int          due;
  bit          p_w;
  int          p_idx;
  logic [31:0] p_d;
  logic [31:0] mm [int];
  bit          m_valid;
  bit          m_write;
  logic [31:0] m_data;

  initial begin
    cyc = 0; pend = 0; due = 0; p_w = 0; p_idx = 0; p_d = 0;
    m_valid = 0; m_write = 0; m_data = 0;
  end

  always @(posedge clk) begin
    cyc++;
    m_valid = 0;
    if (!rst_n) begin
      pend    = 0;
      m_write = 0;
      m_data  = 0;
    end else if (pend) begin
      if (cyc == due) begin
        m_valid = 1;
        m_write = p_w;
        m_data  = mm.exists(p_idx) ? mm[p_idx] : 32'd0;
        if (p_w) mm[p_idx] = p_d;
        pend = 0;
      end
    end else if (bus.req_valid) begin
      pend  = 1;
      due   = cyc + L;
      p_w   = bus.req_write;
      p_idx = int'(bus.req_address % DEP);
      p_d   = bus.req_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Compare process: all outputs are meaningful every cycle.
  always @(negedge clk) begin
    chk("resp_valid", 32'(bus.resp_valid), 32'(m_valid));
    chk("resp_data",  bus.resp_data, m_data);
    chk("resp_write", 32'(bus.resp_write), 32'(m_write));
    chk("req_ready",  32'(bus.req_ready), 32'(!pend));
    chk("busy",       32'(bus.busy), 32'(pend));
  end

  // Single request; optionally scrambles req_* while the DUT is busy.
  task automatic req(input bit w, input logic [31:0] a, input logic [31:0] d,
                     input bit scramble, output logic [31:0] rd, output int lat,
                     output bit rw);
    @(negedge clk);
    bus.req_valid   = 1'b1;
    bus.req_write   = w;
    bus.req_address = a;
    bus.req_data    = d;
    @(negedge clk);
    lat = 0;
    while (!bus.resp_valid && lat < 40) begin
      if (scramble) begin
        bus.req_write   = $urandom_range(0, 1);
        bus.req_address = $urandom;
        bus.req_data    = $urandom;
      end else begin
        bus.req_valid = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.req_valid = 1'b0;
    if (lat >= 40) chk("resp timeout", 32'(lat), 32'(L));
    rd = bus.resp_data;
    rw = bus.resp_write;
  endtask

  logic [31:0] rd;
  int          lat;
  bit          rw;
  int          gap;
  int          pulses;

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0;
    bus.req_address = '0; bus.req_data = '0;
    repeat (3) @(negedge clk);
    chk("reset ready", 32'(bus.req_ready), 32'd1);
    chk("reset busy",  32'(bus.busy), 32'd0);
    chk("reset data",  bus.resp_data, 32'd0);
    rst_n = 1'b1;

    req(1'b1, 32'd0, 32'd14528, 1'b0, rd, lat, rw);
    chk("w0 latency", 32'(lat), 32'd4);
    chk("w0 resp_write", 32'(rw), 32'd1);
    chk("w0 old data", rd, 32'd0);

    req(1'b1, 32'd2816867292, 32'd526421, 1'b0, rd, lat, rw);
    req(1'b0, 32'd3036, 32'd0, 1'b0, rd, lat, rw);
    chk("alias read", rd, 32'd526421);
    chk("alias resp_write", 32'(rw), 32'd0);

    req(1'b1, 32'd1001425, 32'd25369366, 1'b0, rd, lat, rw);
    req(1'b1, 32'd1001425, 32'd14528, 1'b0, rd, lat, rw);
    chk("second write old", rd, 32'd25369366);
    req(1'b0, 32'd1001425, 32'd0, 1'b0, rd, lat, rw);
    chk("read after writes", rd, 32'd14528);

    // Back-to-back reads of address 0 with req_valid held.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0;
    bus.req_address = 32'd0; bus.req_data = 32'd0;
    pulses = 0; gap = 0;
    for (int i = 0; i < 40 && pulses < 3; i++) begin
      @(negedge clk);
      gap++;
      if (bus.resp_valid) begin
        pulses++;
        chk("b2b data", bus.resp_data, 32'd14528);
        if (pulses > 1) chk("b2b spacing", 32'(gap), 32'(L + 1));
        gap = 0;
        if (pulses == 3) bus.req_valid = 1'b0;
      end
    end
    chk("b2b pulses", 32'(pulses), 32'd3);

    // Aborted write: reset two cycles after acceptance.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1;
    bus.req_address = 32'd2001; bus.req_data = 32'd99;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (L + 2) @(negedge clk);
    req(1'b0, 32'd2001, 32'd0, 1'b0, rd, lat, rw);
    chk("abort read", rd, 32'd14528);

    // Inputs changing during WAIT must not affect the latched request.
    req(1'b1, 32'd100, 32'hABCD, 1'b1, rd, lat, rw);
    chk("scramble latency", 32'(lat), 32'd4);
    chk("scramble resp_write", 32'(rw), 32'd1);
    req(1'b0, 32'd100, 32'd0, 1'b1, rd, lat, rw);
    chk("scramble read", rd, 32'hABCD);

    // Randomized traffic on a small aliased address set, with idle gaps.
    for (int n = 0; n < 150; n++) begin
      @(negedge clk);
      bus.req_valid   = ($urandom_range(0, 3) != 0);
      bus.req_write   = $urandom_range(0, 1);
      bus.req_address = ($urandom_range(0, 7) * 32'd4096) + $urandom_range(0, 5);
      bus.req_data    = $urandom;
      if ($urandom_range(0, 40) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
    end
    rst_n = 1'b1;
    bus.req_valid = 1'b0;
    repeat (L + 3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
